// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: line-clear pass controller for a COLS x ROWS falling-block board.
// The board is scanned from the bottom row upward. A full row is removed by copying
// every row above it down by one, then clearing row 0. The same row is re-scanned
// afterwards, because the row that has just moved into it may also be full.
// Optional feature macro: LINE_TOTAL_EN. When it is defined, the module keeps a
// saturating running total of cleared lines. Without it, total_lines is tied to 0.
module line_clear_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] rd_x,
  output logic [4:0] rd_y,
  input  logic       rd_data,
  output logic       we,
  output logic [3:0] wx,
  output logic [4:0] wy,
  output logic       wdata,
  output logic [4:0] lines,
  output logic [7:0] total_lines
);

  localparam logic [3:0] LAST_COL = 4'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    EVAL   = 3'd2,
    SH_RD  = 3'd3,
    SH_WR  = 3'd4,
    SH_CLR = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_col, w_col_next;
  logic [4:0] r_row, w_row_next;
  logic [4:0] r_dst, w_dst_next;
  logic       r_full, w_full_next;
  logic [4:0] r_lines, w_lines_next;
  logic       w_row_full;

  // State and datapath registers; reset abandons any pass in progress.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_dst   <= '0;
      r_full  <= 1'b0;
      r_lines <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_dst   <= w_dst_next;
      r_full  <= w_full_next;
      r_lines <= w_lines_next;
    end
  end

  // The last cell of a row arrives one cycle after its address, during EVAL.
  assign w_row_full = r_full & rd_data;

  // This block computes the next state and drives the board ports.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_dst_next   = r_dst;
    w_full_next  = r_full;
    w_lines_next = r_lines;
    busy         = 1'b1;
    done         = 1'b0;
    rd_x         = '0;
    rd_y         = '0;
    we           = 1'b0;
    wx           = '0;
    wy           = '0;
    wdata        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_lines_next = '0;
          w_row_next   = LAST_ROW;
          w_col_next   = '0;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        rd_x = r_col;
        rd_y = r_row;
        // In the cycle for col 0, rd_data is stale and is not used. The AND chain starts here.
        w_full_next = (r_col == 4'd0) ? 1'b1 : (r_full & rd_data);
        if (r_col == LAST_COL) begin
          w_col_next   = '0;
          w_state_next = EVAL;
        end else begin
          w_col_next = r_col + 4'd1;
        end
      end
      EVAL: begin
        if (w_row_full) begin
          w_dst_next   = r_row;
          w_col_next   = '0;
          // Row 0 has nothing above it to copy down, so it is only cleared.
          w_state_next = (r_row == 5'd0) ? SH_CLR : SH_RD;
        end else if (r_row == 5'd0) begin
          w_state_next = DONE;
        end else begin
          w_row_next   = r_row - 5'd1;
          w_state_next = SCAN;
        end
      end
      SH_RD: begin
        rd_x         = r_col;
        rd_y         = r_dst - 5'd1;
        w_state_next = SH_WR;
      end
      SH_WR: begin
        we    = 1'b1;
        wx    = r_col;
        wy    = r_dst;
        wdata = rd_data;
        if (r_col == LAST_COL) begin
          w_col_next   = '0;
          w_dst_next   = r_dst - 5'd1;
          w_state_next = (r_dst == 5'd1) ? SH_CLR : SH_RD;
        end else begin
          w_col_next   = r_col + 4'd1;
          w_state_next = SH_RD;
        end
      end
      SH_CLR: begin
        we = 1'b1;
        wx = r_col;
        wy = '0;
        if (r_col == LAST_COL) begin
          w_col_next   = '0;
          w_lines_next = r_lines + 5'd1;
          w_state_next = SCAN;
        end else begin
          w_col_next = r_col + 4'd1;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign lines = r_lines;

`ifdef LINE_TOTAL_EN
  logic [7:0] r_total;
  logic [8:0] w_sum;

  assign w_sum = {1'b0, r_total} + {4'b0000, r_lines};

  // Add the count for this pass to the total in the DONE cycle. The total saturates at 255.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_total <= '0;
    end else if (r_state == DONE) begin
      r_total <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign total_lines = r_total;
`else
  assign total_lines = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: directed bench for line_clear_ctrl. A board memory with a
// registered read port is built into the bench. For each pass, a behavioural
// line-clear model pushes the expected result into a scoreboard. The result is
// popped and compared when the DUT pulses done.
module tb_line_clear_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, we, wdata, rd_data;
  logic [3:0] rd_x, wx;
  logic [4:0] rd_y, wy, lines;
  logic [7:0] total_lines;

  logic [9:0]   mem [0:19];
  logic         load_req = 1'b0;
  logic [199:0] load_board = '0;
  int           wr_count = 0;
  int           n_vec = 0;
  int           n_err = 0;
  int           exp_total = 0;

  typedef struct packed {
    logic [4:0]   lines;
    logic [7:0]   total;
    logic [199:0] board;
    int           done_cyc;
  } exp_t;

  exp_t sb [$];

  line_clear_ctrl #(.COLS(10), .ROWS(20)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .we(we), .wx(wx), .wy(wy),
    .wdata(wdata), .lines(lines), .total_lines(total_lines)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) begin
      for (int y = 0; y < 20; y++) mem[y] <= load_board[y*10 +: 10];
      wr_count <= 0;
    end else if (we) begin
      mem[wy][wx] <= wdata;
      wr_count <= wr_count + 1;
    end
    rd_data <= mem[rd_y][rd_x];
  end

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] snapshot();
    logic [199:0] s;
    for (int y = 0; y < 20; y++) s[y*10 +: 10] = mem[y];
    return s;
  endfunction

  // Compact the rows that are not full toward the bottom and fill the top rows with zeros.
  task automatic model(input logic [199:0] b, output logic [199:0] o, output int n);
    int dy;
    o = '0;
    n = 0;
    dy = 19;
    for (int y = 19; y >= 0; y--) begin
      if (&b[y*10 +: 10]) n++;
      else begin
        o[dy*10 +: 10] = b[y*10 +: 10];
        dy--;
      end
    end
  endtask

  task automatic load(input logic [199:0] b);
    @(negedge clk);
    load_board = b;
    load_req   = 1'b1;
    @(negedge clk);
    load_req   = 1'b0;
  endtask

  task automatic run_pass(input string tag, input logic [199:0] b, input int exp_done,
                          input int restart_at);
    exp_t e;
    logic [199:0] ob;
    int n, dc;
    bit found;
    load(b);
    model(b, ob, n);
`ifdef LINE_TOTAL_EN
    exp_total = (exp_total + n > 255) ? 255 : exp_total + n;
`endif
    e.lines = 5'(n);
    e.total = 8'(exp_total);
    e.board = ob;
    e.done_cyc = exp_done;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy@1"}, 200'(busy), 200'(1));
    found = 1'b0;
    dc = 0;
    for (int k = 1; k <= 20000 && !found; k++) begin
      if (k > 1) @(negedge clk);
      start = (k == restart_at);
      if (done) begin
        found = 1'b1;
        dc = k;
        chk({tag, " rd_addr@done"}, 200'({rd_x, rd_y}), 200'(0));
        chk({tag, " we@done"}, 200'(we), 200'(0));
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 200'(found), 200'(1));
    @(negedge clk);
    chk({tag, " done_1cyc"}, 200'(done), 200'(0));
    chk({tag, " idle_after"}, 200'(busy), 200'(0));
    e = sb.pop_front();
    chk({tag, " lines"}, 200'(lines), 200'(e.lines));
    chk({tag, " total"}, 200'(total_lines), 200'(e.total));
    chk({tag, " board"}, snapshot(), e.board);
    if (e.done_cyc >= 0) chk({tag, " done_cycle"}, 200'(dc), 200'(e.done_cyc));
    repeat (3) @(negedge clk);
    chk({tag, " lines_hold"}, 200'(lines), 200'(e.lines));
    chk({tag, " no_queued_start"}, 200'(busy), 200'(0));
    $display("pass %s: done_cycle=%0d lines=%0d total=%0d writes=%0d",
             tag, dc, lines, total_lines, wr_count);
  endtask

  initial begin
    logic [199:0] b;
    int wc;
    bit seen;
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy", 200'(busy), 200'(0));
    chk("rst done", 200'(done), 200'(0));
    chk("rst we", 200'(we), 200'(0));
    chk("rst wdata", 200'(wdata), 200'(0));
    chk("rst rd_addr", 200'({rd_x, rd_y}), 200'(0));
    chk("rst w_addr", 200'({wx, wy}), 200'(0));
    chk("rst lines", 200'(lines), 200'(0));
    chk("rst total", 200'(total_lines), 200'(0));
    start = 1'b0;
    reset = 1'b0;
    $display("reset check: busy=%0d lines=%0d", busy, lines);

    // An empty board uses 1 cycle to enter SCAN and then 20 rows of 11 cycles each.
    run_pass("empty", '0, 221, -1);
    chk("empty writes", 200'(wr_count), 200'(0));

    b = '0; b[190 +: 10] = '1; b[183] = 1'b1;
    run_pass("row19", b, 622, -1);

    // Only row 0 is full: 209 + 11 + 10 + 11 cycles of work, so done arrives at cycle 242.
    b = '0; b[0 +: 10] = '1;
    run_pass("row0", b, 242, -1);

    b = '0; b[160 +: 40] = '1;
    run_pass("four", b, -1, -1);

    b = '0; b[190 +: 10] = '1; b[170 +: 10] = '1; b[180 +: 10] = 10'b1111111110;
    b[0 +: 10] = 10'b0000010001;
    run_pass("gap", b, -1, -1);

    // A random board with two full rows. A second start pulse is sent while busy and must be ignored.
    for (int i = 0; i < 200; i++) b[i] = ($urandom_range(0, 3) != 0);
    for (int y = 0; y < 20; y++) if (y != 10 && y != 15) b[y*10 + 4] = 1'b0;
    b[100 +: 10] = '1; b[150 +: 10] = '1;
    run_pass("rand_restart", b, -1, 40);

    // Reset during the shift must stop the pass immediately.
    b = '0; b[190 +: 10] = '1; b[100 +: 10] = 10'b1010101010;
    load(b);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (we) seen = 1'b1;
    end
    chk("mid we_seen", 200'(seen), 200'(1));
    repeat (5) @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid busy", 200'(busy), 200'(0));
    chk("mid we", 200'(we), 200'(0));
    chk("mid lines", 200'(lines), 200'(0));
    chk("mid total", 200'(total_lines), 200'(0));
    reset = 1'b0;
    start = 1'b0;
    exp_total = 0;
    wc = wr_count;
    repeat (20) @(negedge clk);
    chk("mid no_writes", 200'(wr_count), 200'(wc));
    chk("mid stays_idle", 200'(busy), 200'(0));
    $display("mid-pass reset: writes_before=%0d busy=%0d", wc, busy);

`ifdef LINE_TOTAL_EN
    // Bring the total to 253 with short passes that clear the top rows, then run a 4-line pass.
    for (int p = 0; p < 50; p++) begin
      b = '0; b[0 +: 50] = '1;
      run_pass("top5", b, -1, -1);
    end
    b = '0; b[0 +: 30] = '1;
    run_pass("top3", b, -1, -1);
    chk("total 253", 200'(total_lines), 200'(253));
    b = '0; b[160 +: 40] = '1;
    run_pass("sat", b, -1, -1);
    chk("total sat", 200'(total_lines), 200'(255));
`endif

    chk("sb empty", 200'(sb.size()), 200'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
